ifu_prefetch: RTL and testbench

IFU_PREFETCH -- requirements
Module: ifu_prefetch

---
 rtl/ifu_prefetch_pkg.sv | 30 +++
 rtl/ifu_prefetch_fifo.sv | 52 +++++
 rtl/ifu_prefetch.sv | 122 ++++++++++++
 tb/tb_ifu_prefetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
// Shared defines, fetch-entry type and helpers for the instruction prefetch unit.
// The IFU_ERR_EN macro enables per-entry bus error tracking in ifu_prefetch.
`ifndef IFU_PREFETCH_DEFS
`define IFU_PREFETCH_DEFS
`define STALL_WIDTH    6
`define STALL_PC       0
`define INST_NOP       32'h0000_0013
`define CPU_RESET_ADDR 32'h0000_1000
`endif

package ifu_prefetch_pkg;

  localparam int          STALL_W      = `STALL_WIDTH;
  localparam int          STALL_PC_BIT = `STALL_PC;
  localparam logic [31:0] NOP_INST     = `INST_NOP;
  localparam logic [31:0] RESET_PC     = `CPU_RESET_ADDR;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// fetch_fifo: power-of-two circular buffer holding fetched entries; flush empties it.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so push-while-full is legal then
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: in-order instruction prefetcher with bounded outstanding requests and flush.
// Define IFU_ERR_EN to store bus errors per entry, expose inst_err_o and halt fetch on error.
module ifu_prefetch import ifu_prefetch_pkg::*; #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_ADDR      = `CPU_RESET_ADDR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [31:0]             flush_addr_i,
  input  logic [`STALL_WIDTH-1:0] stall_i,
  output logic [31:0]             inst_o,
  output logic [31:0]             pc_o,
  output logic                    inst_valid_o,
  output logic                    instr_req_o,
  input  logic                    instr_gnt_i,
  output logic [31:0]             instr_addr_o,
  input  logic                    instr_rvalid_i,
  input  logic [31:0]             instr_rdata_i,
  input  logic                    instr_err_i
`ifdef IFU_ERR_EN
  ,
  output logic                    inst_err_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_OS  = CW'(MAX_OUTSTANDING);
`ifdef IFU_ERR_EN
  localparam int FIFO_W = ENTRY_W;
`else
  localparam int FIFO_W = ENTRY_W - 1;
`endif

  logic [31:0]     fetch_addr, resp_pc;
  logic [CW-1:0]   outstanding, discard_cnt, fifo_count, inflight;
  logic            fifo_full, fifo_empty;
  logic            fire, push, pop, stalled, err_lock;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
  fetch_entry_t    head;

  assign stalled  = stall_i[`STALL_PC];
  // slots already promised to the FIFO: queued entries plus requests in flight
  assign inflight = outstanding + fifo_count;

  assign instr_req_o  = rst_n && !flush_i && !err_lock &&
                        (outstanding < MAX_OS) && (inflight < DEPTH_C);
  assign fire         = instr_req_o && instr_gnt_i;
  assign instr_addr_o = word_align(fetch_addr);

  assign push = instr_rvalid_i && !flush_i && (discard_cnt == '0);

`ifdef IFU_ERR_EN
  assign fifo_wdata = {resp_pc, instr_rdata_i, instr_err_i};
  assign head       = fetch_entry_t'(fifo_rdata);
`else
  assign fifo_wdata = {resp_pc, instr_rdata_i};
  assign head       = fetch_entry_t'({fifo_rdata, 1'b0});
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .flush (flush_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign inst_valid_o = !fifo_empty && !flush_i;
  assign pop          = inst_valid_o && !stalled;
  assign inst_o       = inst_valid_o ? head.inst : NOP_INST;
  assign pc_o         = fifo_empty ? resp_pc : head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr  <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      outstanding <= '0;
      discard_cnt <= '0;
    end else if (flush_i) begin
      // everything still in flight is stale; a response landing now is dropped too
      fetch_addr  <= word_align(flush_addr_i);
      resp_pc     <= word_align(flush_addr_i);
      outstanding <= outstanding - CW'(instr_rvalid_i);
      discard_cnt <= outstanding - CW'(instr_rvalid_i);
    end else begin
      if (fire) fetch_addr <= word_align(fetch_addr) + 32'd4;
      outstanding <= outstanding + CW'(fire) - CW'(instr_rvalid_i);
      if (instr_rvalid_i && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
      if (push) resp_pc <= resp_pc + 32'd4;
    end
  end

`ifdef IFU_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err_lock <= 1'b0;
    else if (flush_i)              err_lock <= 1'b0;
    else if (push && instr_err_i)  err_lock <= 1'b1;
  end

  assign inst_err_o = inst_valid_o && head.err;

  logic unused_ok;
  assign unused_ok = ^{flush_addr_i[1:0], stall_i, fifo_full};
`else
  assign err_lock = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{flush_addr_i[1:0], stall_i, fifo_full, instr_err_i, head.err};
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: in-order bus responder model with variable latency,
// expected entries queued when a response is driven and compared when the head pops.
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush_i;
  logic [31:0]        flush_addr_i;
  logic [STALL_W-1:0] stall_i;
  logic [31:0]        inst_o, pc_o, instr_addr_o, instr_rdata_i;
  logic               inst_valid_o, instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
`ifdef IFU_ERR_EN
  logic               inst_err_o;
`endif

  always #5 clk = ~clk;

  ifu_prefetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .flush_addr_i   (flush_addr_i),
    .stall_i        (stall_i),
    .inst_o         (inst_o),
    .pc_o           (pc_o),
    .inst_valid_o   (inst_valid_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i)
`ifdef IFU_ERR_EN
    ,
    .inst_err_o     (inst_err_o)
`endif
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } exp_t;

  pend_t pend[$];
  exp_t  exp_q[$];

  int errs = 0, checks = 0, cyc = 0;
  int lat = 1, gnt_pct = 100, err_on_rsp = -1, rsp_num = 0;
  bit stall = 0, flush = 0, exp_lock = 0;
  logic [31:0] faddr = '0;
  logic [31:0] exp_fetch = RESET_PC, exp_rpc = RESET_PC;
  int fires = 0, pops = 0, first_fire_cyc = -1, first_valid_cyc = -1;
  logic [31:0] first_fire_addr, first_pop_pc, hold_pc, hold_inst;
  logic [31:0] fire_log[3];
  logic second_err;
  bit have_hold;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A3C_9600 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit drv_rv, rsp_err, exp_req;
    pend_t p;
    exp_t e;
    @(negedge clk);
    instr_gnt_i  = ($urandom_range(99) < gnt_pct);
    stall_i      = STALL_W'($urandom);
    stall_i[STALL_PC_BIT] = stall;
    flush_i      = flush;
    flush_addr_i = faddr;
    drv_rv       = (pend.size() > 0) && (pend[0].due <= cyc);
    rsp_err      = (rsp_num == err_on_rsp);
`ifndef IFU_ERR_EN
    rsp_err      = 1'($urandom_range(1));
`endif
    instr_rvalid_i = drv_rv;
    instr_rdata_i  = drv_rv ? dat(pend[0].addr) : $urandom;
    instr_err_i    = rsp_err;
    #1;
    exp_req = !flush && !exp_lock && (pend.size() < 2) && (pend.size() + exp_q.size() < 4);
    chk("req", 32'(instr_req_o), 32'(exp_req));
    chk("valid", 32'(inst_valid_o), 32'((exp_q.size() != 0) && !flush));
    if (!inst_valid_o) chk("nop", inst_o, NOP_INST);
    if (exp_q.size() == 0) chk("pc_empty", pc_o, exp_rpc);
    if (inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (inst_valid_o && !stall && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", pc_o, e.pc);
      chk("inst", inst_o, e.inst);
`ifdef IFU_ERR_EN
      chk("err", 32'(inst_err_o), 32'(e.err));
      if (pops == 1) second_err = inst_err_o;
`endif
      if (pops == 0) first_pop_pc = pc_o;
      pops++;
    end
    if (drv_rv) begin
      p = pend.pop_front();
      rsp_num++;
      if (!p.stale && !flush) begin
        exp_q.push_back('{p.addr, dat(p.addr), rsp_err});
        exp_rpc += 32'd4;
`ifdef IFU_ERR_EN
        if (rsp_err) exp_lock = 1;
`endif
      end
    end
    if (instr_req_o && instr_gnt_i) begin
      chk("addr", instr_addr_o, exp_fetch);
      if (fires == 0) begin first_fire_addr = instr_addr_o; first_fire_cyc = cyc; end
      if (fires < 3) fire_log[fires] = instr_addr_o;
      pend.push_back('{exp_fetch, cyc + lat, 1'b0});
      exp_fetch += 32'd4;
      fires++;
    end
    if (flush) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_fetch = {faddr[31:2], 2'b00};
      exp_rpc   = exp_fetch;
      exp_lock  = 0;
    end
    cyc++;
  endtask

  task automatic do_flush(input logic [31:0] a);
    flush = 1; faddr = a;
    cycle();
    flush = 0;
    fires = 0; pops = 0;
  endtask

  task automatic drain();
    gnt_pct = 0;
    for (int i = 0; i < 6; i++) cycle();
    gnt_pct = 100;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    flush_i = 0; flush_addr_i = '0; stall_i = '0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0; instr_err_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, NOP_INST);
    chk("rst_pc", pc_o, RESET_PC);
`ifdef IFU_ERR_EN
    chk("rst_err", 32'(inst_err_o), 32'd0);
`endif
    rst_n = 1'b1;

    // sequential fetch from reset, one-cycle latency
    fires = 0; pops = 0; first_fire_cyc = -1; first_valid_cyc = -1;
    for (int i = 0; i < 10; i++) cycle();
    chk("first_addr", first_fire_addr, RESET_PC);
    chk("first_lat", 32'(first_valid_cyc - first_fire_cyc), 32'd2);
    chk("first_pc", first_pop_pc, RESET_PC);

    // stall fills the FIFO and freezes the head
    do_flush(32'h0000_2000);
    stall = 1; have_hold = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (inst_valid_o) begin
        if (!have_hold) begin hold_pc = pc_o; hold_inst = inst_o; have_hold = 1; end
        else begin chk("hold_pc", pc_o, hold_pc); chk("hold_inst", inst_o, hold_inst); end
      end
    end
    chk("stall_fires", 32'(fires), 32'd4);
    chk("stall_req", 32'(instr_req_o), 32'd0);
    stall = 0; pops = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("release_pops", 32'(pops), 32'd4);

    // outstanding limit with 3-cycle latency, then flush with two in flight
    drain();
    lat = 3;
    do_flush(32'h0000_0400);
    for (int i = 0; i < 3; i++) cycle();
    chk("os_fires", 32'(fires), 32'd2);
    chk("os_pend", 32'(pend.size()), 32'd2);
    do_flush(32'h0000_0102);
    for (int i = 0; i < 12; i++) cycle();
    chk("flush_addr", first_fire_addr, 32'h0000_0100);
    chk("flush_pc", first_pop_pc, 32'h0000_0100);

    // address wrap
    drain();
    lat = 1;
    do_flush(32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) cycle();
    chk("wrap0", fire_log[0], 32'hFFFF_FFF8);
    chk("wrap1", fire_log[1], 32'hFFFF_FFFC);
    chk("wrap2", fire_log[2], 32'h0000_0000);

    // random traffic: grant gaps, mixed latency, stalls and flushes
    gnt_pct = 70;
    for (int i = 0; i < 400; i++) begin
      lat   = $urandom_range(3, 1);
      stall = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 4) do_flush($urandom);
      else cycle();
    end
    stall = 0; lat = 1;
    drain();

`ifdef IFU_ERR_EN
    // bus error on the second response halts fetch until the next flush
    do_flush(32'h0000_0040);
    err_on_rsp = rsp_num + 1;
    second_err = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("err_fires", 32'(fires), 32'd3);
    chk("err_2nd", 32'(second_err), 32'd1);
    chk("err_req", 32'(instr_req_o), 32'd0);
    err_on_rsp = -1;
    do_flush(32'h0000_0080);
    for (int i = 0; i < 6; i++) cycle();
    chk("err_resume", first_fire_addr, 32'h0000_0080);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
